// File: rtl/pc_flow_ctrl_pkg.sv
// Shared encodings for the next-PC sequencer: PC mux select codes (reused by the PC mux)
// and the flow-control state encoding.
package pc_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_NEXT_INS = 2'b00,
        PC_JUMP     = 2'b01,
        PC_BRANCH   = 2'b10,
        PC_NOOP     = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_flow_cnt.sv
// Loadable saturating down-counter with zero flag; times STALL and FLUSH sequences.
module pc_flow_cnt
    import pc_flow_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/pc_flow_ctrl.sv
// Next-PC / pipeline stall-flush sequencer. Optional perf counters: define PC_FLOW_PERF_CNT_EN
// to add stall_cnt/flush_cnt outputs.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 0,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic        jump_req,
    input  logic        load_use,
    input  logic        halt_req,
    input  logic        resume,
    output logic [1:0]  pc_sel,
    output logic        pc_we,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted
`ifdef PC_FLOW_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] LP_STALL_LOAD = CNT_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] LP_FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_e           r_state;
    logic             r_halted;
    state_e           w_next;
    pc_sel_e          w_sel;
    logic             w_we;
    logic             w_stall;
    logic             w_if_flush;
    logic             w_ex_flush;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_branch_now;
    logic             w_stall_last;

    pc_flow_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // The load_use cycle itself is the first bubble, so STALL ends as the count reaches zero.
    assign w_stall_last = w_zero || (w_count == CNT_W'(1));
    assign w_branch_now = branch_taken && ((r_state == ST_RUN) || (r_state == ST_STALL));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_sel      = PC_NEXT_INS;
        w_we       = 1'b1;
        w_stall    = 1'b0;
        w_if_flush = 1'b0;
        w_ex_flush = 1'b0;
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = LP_STALL_LOAD;
        w_dec      = 1'b0;

        if (w_branch_now) begin
            w_sel      = PC_BRANCH;
            w_if_flush = 1'b1;
            w_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                w_next     = ST_FLUSH;
                w_load     = 1'b1;
                w_load_val = LP_FLUSH_LOAD;
            end else begin
                w_next = ST_RUN;
            end
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (jump_req) begin
                        w_sel      = PC_JUMP;
                        w_if_flush = 1'b1;
                    end else if (load_use) begin
                        w_we       = 1'b0;
                        w_stall    = 1'b1;
                        w_ex_flush = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            w_next = ST_STALL;
                            w_load = 1'b1;
                        end
                    end else if (halt_req) begin
                        w_sel  = PC_NOOP;
                        w_next = ST_HALT;
                    end
                end
                ST_STALL: begin
                    w_we       = 1'b0;
                    w_stall    = 1'b1;
                    w_ex_flush = 1'b1;
                    w_dec      = 1'b1;
                    if (w_stall_last) w_next = ST_RUN;
                end
                ST_FLUSH: begin
                    w_if_flush = 1'b1;
                    w_dec      = 1'b1;
                    if (w_zero) w_next = ST_RUN;
                end
                ST_HALT: begin
                    w_sel = PC_NOOP;
                    w_we  = 1'b0;
                    if (resume) w_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == ST_HALT);
        end
    end

    // Outputs drop to their idle values the moment reset asserts, not at the next edge.
    assign pc_sel      = rst_n ? w_sel      : PC_NEXT_INS;
    assign pc_we       = rst_n & w_we;
    assign if_id_stall = rst_n & w_stall;
    assign if_id_flush = rst_n & w_if_flush;
    assign id_ex_flush = rst_n & w_ex_flush;
    assign halted      = r_halted;

`ifdef PC_FLOW_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_we && ((r_state == ST_RUN) || (r_state == ST_STALL)))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_if_flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed testbench for pc_flow_ctrl (STALL_CYCLES=2, FLUSH_CYCLES=2); also covers the
// PC_FLOW_PERF_CNT_EN build when that macro is defined.
module tb_pc_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump_req = 1'b0;
    logic        load_use = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [1:0]  pc_sel;
    logic        pc_we;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
`ifdef PC_FLOW_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Output vector: {pc_sel[1:0], pc_we, if_id_stall, if_id_flush, id_ex_flush, halted}
    localparam logic [6:0] V_RESET    = 7'b00_0_0_0_0_0;
    localparam logic [6:0] V_IDLE     = 7'b00_1_0_0_0_0;
    localparam logic [6:0] V_STALL    = 7'b00_0_1_0_1_0;
    localparam logic [6:0] V_BRANCH   = 7'b10_1_0_1_1_0;
    localparam logic [6:0] V_FLUSH    = 7'b00_1_0_1_0_0;
    localparam logic [6:0] V_JUMP     = 7'b01_1_0_1_0_0;
    localparam logic [6:0] V_HALT_REQ = 7'b11_1_0_0_0_0;
    localparam logic [6:0] V_HALT     = 7'b11_0_0_0_0_1;

    // Stimulus vector: {branch_taken, jump_req, load_use, halt_req, resume}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_BR   = 5'b10000;
    localparam logic [4:0] S_J    = 5'b01000;
    localparam logic [4:0] S_LU   = 5'b00100;
    localparam logic [4:0] S_HR   = 5'b00010;
    localparam logic [4:0] S_RS   = 5'b00001;

    always #5 clk = ~clk;

    pc_flow_ctrl #(
        .STALL_CYCLES (2),
        .FLUSH_CYCLES (2),
        .CNT_W        (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .jump_req     (jump_req),
        .load_use     (load_use),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_sel       (pc_sel),
        .pc_we        (pc_we),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .halted       (halted)
`ifdef PC_FLOW_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    function automatic logic [6:0] outs();
        return {pc_sel, pc_we, if_id_stall, if_id_flush, id_ex_flush, halted};
    endfunction

    // Apply one cycle of requests after the falling edge; outputs settle before the next rising edge.
    task automatic drive(input logic [4:0] s);
        @(negedge clk);
        {branch_taken, jump_req, load_use, halt_req, resume} = s;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if (outs() !== V_RESET) $display("FAIL reset_hold: got %b expected %b", outs(), V_RESET);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(S_NONE);
            n_total++;
            if (outs() !== V_IDLE) $display("FAIL reset_idle[%0d]: got %b expected %b", i, outs(), V_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        logic [4:0] stim [3];
        logic [6:0] expv [3];
        stim = '{S_LU, S_NONE, S_NONE};
        expv = '{V_STALL, V_STALL, V_IDLE};
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            n_total++;
            if (outs() !== expv[i]) $display("FAIL load_use[%0d]: got %b expected %b", i, outs(), expv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_branch_flush();
        logic [4:0] stim [4];
        logic [6:0] expv [4];
        stim = '{S_BR, S_J, S_NONE, S_NONE};
        expv = '{V_BRANCH, V_FLUSH, V_FLUSH, V_IDLE};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            n_total++;
            if (outs() !== expv[i]) $display("FAIL branch_flush[%0d]: got %b expected %b", i, outs(), expv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [4:0] stim [13];
        logic [6:0] expv [13];
        stim = '{S_BR | S_J | S_LU, S_NONE, S_NONE, S_NONE,
                 S_LU, S_BR, S_NONE, S_NONE, S_NONE,
                 S_J | S_LU, S_LU | S_HR, S_NONE, S_NONE};
        expv = '{V_BRANCH, V_FLUSH, V_FLUSH, V_IDLE,
                 V_STALL, V_BRANCH, V_FLUSH, V_FLUSH, V_IDLE,
                 V_JUMP, V_STALL, V_STALL, V_IDLE};
        for (int i = 0; i < 13; i++) begin
            drive(stim[i]);
            n_total++;
            if (outs() !== expv[i]) $display("FAIL priority[%0d]: got %b expected %b", i, outs(), expv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        logic [4:0] stim [7];
        logic [6:0] expv [7];
        stim = '{S_HR, S_J, S_BR, S_LU, S_HR, S_RS | S_HR, S_NONE};
        expv = '{V_HALT_REQ, V_HALT, V_HALT, V_HALT, V_HALT, V_HALT, V_IDLE};
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            n_total++;
            if (outs() !== expv[i]) $display("FAIL halt[%0d]: got %b expected %b", i, outs(), expv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(S_BR);
        n_total++;
        if (outs() !== V_BRANCH) $display("FAIL rst_flush_branch: got %b expected %b", outs(), V_BRANCH);
        else n_pass++;
        drive(S_NONE);
        n_total++;
        if (outs() !== V_FLUSH) $display("FAIL rst_flush_pre: got %b expected %b", outs(), V_FLUSH);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (outs() !== V_RESET) $display("FAIL rst_flush_async: got %b expected %b", outs(), V_RESET);
        else n_pass++;
`ifdef PC_FLOW_PERF_CNT_EN
        n_total++;
        if (stall_cnt !== 32'd0) $display("FAIL perf_stall_reset: got %0d expected 0", stall_cnt);
        else n_pass++;
        n_total++;
        if (flush_cnt !== 32'd0) $display("FAIL perf_flush_reset: got %0d expected 0", flush_cnt);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (outs() !== V_IDLE) $display("FAIL rst_flush_release: got %b expected %b", outs(), V_IDLE);
        else n_pass++;
        drive(S_NONE);
        n_total++;
        if (outs() !== V_IDLE) $display("FAIL rst_flush_run: got %b expected %b", outs(), V_IDLE);
        else n_pass++;
    endtask

`ifdef PC_FLOW_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [4:0] stim [6];
        stim = '{S_LU, S_NONE, S_BR, S_NONE, S_NONE, S_NONE};
        for (int i = 0; i < 6; i++) drive(stim[i]);
        n_total++;
        if (stall_cnt !== 32'd2) $display("FAIL perf_stall: got %0d expected 2", stall_cnt);
        else n_pass++;
        n_total++;
        if (flush_cnt !== 32'd3) $display("FAIL perf_flush: got %0d expected 3", flush_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_flush();
        test_priority();
        test_halt();
        test_reset_mid_flush();
`ifdef PC_FLOW_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
